// File: rtl/kiu_pkg.sv
// ----------------------------------------------------------------------------
// kiu_pkg
// Shared definitions for the KIU external interrupt responder:
//   - kiu_state_e      : responder FSM states (IDLE / PEND / ACK)
//   - KIU_IRQ_VECTOR   : default handler address for a maskable IRQ
//   - KIU_URQ_VECTOR   : default handler address for a non-maskable URQ
//   - KIU_SYNC_STAGES  : default depth of the request synchroniser
// ----------------------------------------------------------------------------
package kiu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for a request edge from the controller
      PEND = 2'd1,   // interrupt presented to the pipeline
      ACK  = 2'd2    // pipeline took it; toggle the acknowledge once
   } kiu_state_e;

   localparam logic [31:0] KIU_IRQ_VECTOR  = 32'h0000_0008;
   localparam logic [31:0] KIU_URQ_VECTOR  = 32'h0000_0004;
   localparam int          KIU_SYNC_STAGES = 2;

endpackage

// File: rtl/kiu_sync_chain.sv
// ----------------------------------------------------------------------------
// kiu_sync_chain
// Multi-flop synchroniser that brings a single-bit signal from the IO clock
// domain into the system clock domain. All stages clear on reset.
//
// Parameters:
//   STAGES : number of flip-flops in the chain (at least 2)
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   d      in   asynchronous input bit
//   q      out  synchronised output (last stage of the chain)
// ----------------------------------------------------------------------------
module kiu_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   // Depths below 2 give no metastability protection; clamp to 2.
   localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/kiu_ext_int_responder.sv
// ----------------------------------------------------------------------------
// kiu_ext_int_responder
// KIU-side responder for the external interrupt request/acknowledge
// protocol. A request pulse from the external interrupt controller (IO clock
// domain) is synchronised, edge-detected and turned into a pending IRQ
// (maskable) or URQ (non-maskable) for the core pipeline. When the pipeline
// takes the interrupt, the acknowledge line to the controller toggles once.
//
// Optional build macro:
//   KIU_SPURIOUS_DET_EN : enables the sticky Spurious protocol-violation flag.
//                         Without it Spurious is tied 0.
//
// Parameters:
//   SYNC_STAGES  : request synchroniser depth (minimum 2)
//   IRQ_VECTOR   : handler address for an IRQ (EIC_IntId = 0)
//   URQ_VECTOR   : handler address for a URQ (EIC_IntId = 1)
//
// Ports:
//   Clock             in   system clock
//   Reset             in   asynchronous, active-high reset
//   EIC_IntReq        in   request pulse from the controller (IO domain)
//   EIC_IntId         in   0 = IRQ, 1 = URQ; stable around the request
//   EIC_IntAck        out  toggle acknowledge back to the controller
//   Core_IntEnable    in   core interrupt enable; masks IRQ only
//   Core_IntReq       out  interrupt pending to the pipeline
//   Core_IntIsUrgent  out  pending interrupt is a URQ
//   Core_IntVector    out  handler address of the pending interrupt
//   Core_IntAck       in   one-cycle pulse: pipeline took the interrupt
//   Spurious          out  sticky protocol-violation flag
// ----------------------------------------------------------------------------
module kiu_ext_int_responder
   import kiu_pkg::*;
#(
   parameter int          SYNC_STAGES = KIU_SYNC_STAGES,
   parameter logic [31:0] IRQ_VECTOR  = KIU_IRQ_VECTOR,
   parameter logic [31:0] URQ_VECTOR  = KIU_URQ_VECTOR
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        EIC_IntReq,
   input  logic        EIC_IntId,
   output logic        EIC_IntAck,
   input  logic        Core_IntEnable,
   output logic        Core_IntReq,
   output logic        Core_IntIsUrgent,
   output logic [31:0] Core_IntVector,
   input  logic        Core_IntAck,
   output logic        Spurious
);

   kiu_state_e  state;
   kiu_state_e  state_next;

   logic        req_sync;
   logic        req_sync_last;
   logic        req_rise;
   logic        is_urgent;
   logic        ack_level;

   logic        core_req;
   logic        core_urgent;
   logic [31:0] core_vector;

   // ------------------------------------------------------------------------
   // Request synchroniser and rising-edge detector
   // ------------------------------------------------------------------------
   kiu_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk (Clock),
      .rst (Reset),
      .d   (EIC_IntReq),
      .q   (req_sync)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         req_sync_last <= 1'b0;
      end else begin
         req_sync_last <= req_sync;
      end
   end

   // A controller pulse may span several system clocks; only its leading
   // edge counts as a request.
   assign req_rise = req_sync & ~req_sync_last;

   // ------------------------------------------------------------------------
   // FSM state register plus the latched interrupt type
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         is_urgent <= 1'b0;
      end else begin
         state <= state_next;
         // EIC_IntId is held stable by the controller across the whole
         // request, so sampling it on the qualifying edge is safe.
         if (state == IDLE && req_rise) begin
            is_urgent <= EIC_IntId;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and pipeline-facing outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      core_req    = 1'b0;
      core_urgent = 1'b0;
      core_vector = IRQ_VECTOR;

      case (state)
         IDLE: begin
            // Request edges are only accepted here; elsewhere they drop.
            if (req_rise) begin
               state_next = PEND;
            end
         end

         PEND: begin
            // A URQ ignores the enable; an IRQ follows it combinationally,
            // so dropping the enable withdraws the request in the same cycle
            // while the interrupt itself stays pending.
            core_req    = is_urgent | Core_IntEnable;
            core_urgent = is_urgent;
            core_vector = is_urgent ? URQ_VECTOR : IRQ_VECTOR;
            if (Core_IntAck && core_req) begin
               state_next = ACK;
            end
         end

         ACK: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign Core_IntReq      = core_req;
   assign Core_IntIsUrgent = core_urgent;
   assign Core_IntVector   = core_vector;

   // ------------------------------------------------------------------------
   // Toggle acknowledge: one flip per pass through ACK
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ack_level <= 1'b0;
      end else if (state == ACK) begin
         ack_level <= ~ack_level;
      end
   end

   assign EIC_IntAck = ack_level;

   // ------------------------------------------------------------------------
   // Protocol-violation detection
   // ------------------------------------------------------------------------
`ifdef KIU_SPURIOUS_DET_EN
   logic spurious_flag;

   // Sticky until reset: a second request before the first was acknowledged,
   // or a pipeline acknowledge with nothing pending.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         spurious_flag <= 1'b0;
      end else if ((req_rise && state != IDLE) ||
                   (Core_IntAck && state != PEND)) begin
         spurious_flag <= 1'b1;
      end
   end

   assign Spurious = spurious_flag;
`else
   assign Spurious = 1'b0;
`endif

endmodule

// File: tb/tb_kiu_ext_int_responder.sv
module tb_kiu_ext_int_responder;

   logic        Clock;
   logic        Reset;
   logic        EIC_IntReq;
   logic        EIC_IntId;
   logic        EIC_IntAck;
   logic        Core_IntEnable;
   logic        Core_IntReq;
   logic        Core_IntIsUrgent;
   logic [31:0] Core_IntVector;
   logic        Core_IntAck;
   logic        Spurious;

   int checks;
   int errors;
   logic exp_ack;
   logic exp_spur;

   localparam logic [31:0] VEC_IRQ = 32'h0000_0008;
   localparam logic [31:0] VEC_URQ = 32'h0000_0004;

   kiu_ext_int_responder dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .EIC_IntReq       (EIC_IntReq),
      .EIC_IntId        (EIC_IntId),
      .EIC_IntAck       (EIC_IntAck),
      .Core_IntEnable   (Core_IntEnable),
      .Core_IntReq      (Core_IntReq),
      .Core_IntIsUrgent (Core_IntIsUrgent),
      .Core_IntVector   (Core_IntVector),
      .Core_IntAck      (Core_IntAck),
      .Spurious         (Spurious)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Request pulse two system clocks long; afterwards two edges have
   // sampled EIC_IntReq=1.
   task automatic pulse_req(input logic id);
      EIC_IntId  = id;
      EIC_IntReq = 1'b1;
      tick();
      tick();
      EIC_IntReq = 1'b0;
   endtask

   // One-cycle pipeline acknowledge; returns just after the sampling edge.
   task automatic pulse_core_ack();
      Core_IntAck = 1'b1;
      tick();
      Core_IntAck = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      checks++; if (EIC_IntAck !== 1'b0) begin errors++; $display("FAIL reset_eic_ack: got %b want 0", EIC_IntAck); end
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL reset_core_req: got %b want 0", Core_IntReq); end
      checks++; if (Core_IntIsUrgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b want 0", Core_IntIsUrgent); end
      checks++; if (Core_IntVector !== VEC_IRQ) begin errors++; $display("FAIL reset_vector: got %h want %h", Core_IntVector, VEC_IRQ); end
      checks++; if (Spurious !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b want 0", Spurious); end
      Reset = 1'b0;
      exp_ack = 1'b0;
      exp_spur = 1'b0;
      tick();
   endtask

   task automatic test_irq_enabled();
      Core_IntEnable = 1'b1;
      EIC_IntId  = 1'b0;
      EIC_IntReq = 1'b1;
      tick();   // edge 1 samples the request
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL irq_lat_e1: got %b want 0", Core_IntReq); end
      tick();   // edge 2
      EIC_IntReq = 1'b0;
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL irq_lat_e2: got %b want 0", Core_IntReq); end
      tick();   // edge 3
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL irq_lat_e3: got %b want 1", Core_IntReq); end
      checks++; if (Core_IntIsUrgent !== 1'b0) begin errors++; $display("FAIL irq_urgent: got %b want 0", Core_IntIsUrgent); end
      checks++; if (Core_IntVector !== VEC_IRQ) begin errors++; $display("FAIL irq_vector: got %h want %h", Core_IntVector, VEC_IRQ); end
      pulse_core_ack();   // edge that samples Core_IntAck
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL irq_ack_early: got %b want %b", EIC_IntAck, exp_ack); end
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL irq_req_in_ack: got %b want 0", Core_IntReq); end
      tick();
      exp_ack = ~exp_ack;
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL irq_ack_toggle: got %b want %b", EIC_IntAck, exp_ack); end
      tick();
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL irq_idle_req: got %b want 0", Core_IntReq); end
   endtask

   task automatic test_urq_masked();
      Core_IntEnable = 1'b0;
      pulse_req(1'b1);
      tick();
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL urq_req: got %b want 1", Core_IntReq); end
      checks++; if (Core_IntIsUrgent !== 1'b1) begin errors++; $display("FAIL urq_urgent: got %b want 1", Core_IntIsUrgent); end
      checks++; if (Core_IntVector !== VEC_URQ) begin errors++; $display("FAIL urq_vector: got %h want %h", Core_IntVector, VEC_URQ); end
      pulse_core_ack();
      tick();
      exp_ack = ~exp_ack;
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL urq_ack_toggle: got %b want %b", EIC_IntAck, exp_ack); end
      checks++; if (Core_IntIsUrgent !== 1'b0) begin errors++; $display("FAIL urq_urgent_clear: got %b want 0", Core_IntIsUrgent); end
      tick();
   endtask

   task automatic test_masked_irq();
      Core_IntEnable = 1'b0;
      pulse_req(1'b0);
      tick();
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL masked_req: got %b want 0", Core_IntReq); end
      pulse_core_ack();   // ignored while masked
      tick();
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL masked_ack_ignored: got %b want %b", EIC_IntAck, exp_ack); end
      Core_IntEnable = 1'b1;
      #1;
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL masked_enable_req: got %b want 1", Core_IntReq); end
      checks++; if (Core_IntVector !== VEC_IRQ) begin errors++; $display("FAIL masked_vector: got %h want %h", Core_IntVector, VEC_IRQ); end
      Core_IntEnable = 1'b0;
      #1;
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL masked_enable_drop: got %b want 0", Core_IntReq); end
      tick();
      Core_IntEnable = 1'b1;
      #1;
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL masked_still_pend: got %b want 1", Core_IntReq); end
      pulse_core_ack();
      tick();
      exp_ack = ~exp_ack;
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL masked_ack_toggle: got %b want %b", EIC_IntAck, exp_ack); end
      tick();
   endtask

   task automatic test_back_to_back();
      Core_IntEnable = 1'b1;
      for (int n = 0; n < 2; n++) begin
         pulse_req(1'b0);
         tick();
         checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL b2b_req_%0d: got %b want 1", n, Core_IntReq); end
         pulse_core_ack();
         tick();
         exp_ack = ~exp_ack;
         checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL b2b_ack_%0d: got %b want %b", n, EIC_IntAck, exp_ack); end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_req_%0d: got %b want 0", k, Core_IntReq); end
      end
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL b2b_ack_stable: got %b want %b", EIC_IntAck, exp_ack); end
   endtask

   task automatic test_reset_mid_pend();
      Core_IntEnable = 1'b1;
      // Make sure the ack line is high so that reset visibly clears it.
      if (exp_ack == 1'b0) begin
         pulse_req(1'b0);
         tick();
         pulse_core_ack();
         tick();
         exp_ack = 1'b1;
      end
      checks++; if (EIC_IntAck !== 1'b1) begin errors++; $display("FAIL rst_pre_ack: got %b want 1", EIC_IntAck); end
      pulse_req(1'b1);
      tick();
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", Core_IntReq); end
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", Core_IntReq); end
      checks++; if (EIC_IntAck !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b want 0", EIC_IntAck); end
      checks++; if (Core_IntIsUrgent !== 1'b0) begin errors++; $display("FAIL rst_mid_urgent: got %b want 0", Core_IntIsUrgent); end
      checks++; if (Core_IntVector !== VEC_IRQ) begin errors++; $display("FAIL rst_mid_vector: got %h want %h", Core_IntVector, VEC_IRQ); end
      exp_ack = 1'b0;
      exp_spur = 1'b0;
      tick();
      Reset = 1'b0;
      tick();
      checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL rst_after_req: got %b want 0", Core_IntReq); end
      pulse_req(1'b0);
      tick();
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL rst_new_req: got %b want 1", Core_IntReq); end
      pulse_core_ack();
      tick();
      exp_ack = 1'b1;
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL rst_new_ack: got %b want %b", EIC_IntAck, exp_ack); end
      tick();
   endtask

   task automatic test_spurious();
`ifdef KIU_SPURIOUS_DET_EN
      logic det = 1'b1;
`else
      logic det = 1'b0;
`endif
      Core_IntEnable = 1'b1;
      pulse_req(1'b0);
      tick();
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL spur_first_req: got %b want 1", Core_IntReq); end
      pulse_req(1'b0);   // second request while pending
      tick();
      tick();
      exp_spur = det;
      checks++; if (Spurious !== exp_spur) begin errors++; $display("FAIL spur_flag: got %b want %b", Spurious, exp_spur); end
      checks++; if (Core_IntReq !== 1'b1) begin errors++; $display("FAIL spur_still_pend: got %b want 1", Core_IntReq); end
      pulse_core_ack();
      tick();
      exp_ack = ~exp_ack;
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL spur_ack_toggle: got %b want %b", EIC_IntAck, exp_ack); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (Core_IntReq !== 1'b0) begin errors++; $display("FAIL spur_dropped_%0d: got %b want 0", k, Core_IntReq); end
      end
      checks++; if (Spurious !== exp_spur) begin errors++; $display("FAIL spur_sticky: got %b want %b", Spurious, exp_spur); end
      // Pipeline acknowledge in IDLE: no toggle; flags only when detecting.
      pulse_core_ack();
      tick();
      tick();
      checks++; if (EIC_IntAck !== exp_ack) begin errors++; $display("FAIL idle_ack_ignored: got %b want %b", EIC_IntAck, exp_ack); end
      checks++; if (Spurious !== det) begin errors++; $display("FAIL idle_ack_spur: got %b want %b", Spurious, det); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_ack = 1'b0;
      exp_spur = 1'b0;
      Reset = 1'b1;
      EIC_IntReq = 1'b0;
      EIC_IntId = 1'b0;
      Core_IntEnable = 1'b0;
      Core_IntAck = 1'b0;

      test_reset();
      test_irq_enabled();
      test_urq_masked();
      test_masked_irq();
      test_back_to_back();
      test_reset_mid_pend();
      test_spurious();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
